// File: rtl/sdram_burst_packer.sv
// Client front end for a BL8 SDRAM controller: packs single-word writes into masked
// 8-word line writes, forwards reads as 8-word bursts and schedules auto-refresh.
module sdram_burst_packer #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 24,
    parameter int REFRESH_CYCLES = 1250,
    parameter int FLUSH_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_ready,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic              req_refresh,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_wmask,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_wdata_next,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              refresh_err
);
    localparam int TAG_W = ADDR_W - 3;
    localparam int RC_W  = $clog2(REFRESH_CYCLES);
    localparam int IC_W  = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REFRESH, S_FLUSH_REQ, S_FLUSH_DATA, S_RD_REQ, S_RD_DATA
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] line_reg [8];
    logic [7:0]        mask_reg, mask_next;
    logic [TAG_W-1:0]  tag_reg;
    logic [2:0]        beat_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [RC_W-1:0]   ref_cnt_reg;
    logic [3:0]        debt_reg, debt_next;
    logic [IC_W-1:0]   idle_cnt_reg;
    logic              ctrl_ready_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_data_valid_reg;
    logic              refresh_err_reg;

    logic tag_hit, wr_accept, rd_accept, flush_trig, flush_done, rd_done;
    logic expire, ref_hs, req_hs;

    // Registered ctrl_ready keeps the handshake readies low while rst is asserted.
    assign tag_hit    = (tag_reg == wr_addr[ADDR_W-1:3]);
    assign wr_ready   = (state_reg == S_IDLE) && ctrl_ready_reg && ((mask_reg == 8'h00) || tag_hit);
    assign rd_ready   = (state_reg == S_IDLE) && ctrl_ready_reg && (mask_reg == 8'h00) && (debt_reg == 4'd0);
    assign wr_accept  = wr_valid && wr_ready;
    assign rd_accept  = rd_valid && rd_ready;
    assign flush_trig = (mask_reg != 8'h00) &&
                        ((mask_reg == 8'hFF) || (wr_valid && !tag_hit) || rd_valid ||
                         (idle_cnt_reg == IC_W'(FLUSH_TIMEOUT)));
    assign flush_done = (state_reg == S_FLUSH_DATA) && req_wdata_next && (beat_reg == 3'd7);
    assign rd_done    = (state_reg == S_RD_DATA) && resp_valid && (beat_reg == 3'd7);
    assign expire     = ctrl_ready_reg && (ref_cnt_reg == '0);
    assign ref_hs     = (state_reg == S_REFRESH) && req_ready;
    assign req_hs     = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (ctrl_ready_reg) begin
                    if (debt_reg != 4'd0)  state_next = S_REFRESH;
                    else if (flush_trig)   state_next = S_FLUSH_REQ;
                    else if (rd_accept)    state_next = S_RD_REQ;
                end
            end
            S_REFRESH:    if (req_ready)  state_next = S_IDLE;
            S_FLUSH_REQ:  if (req_ready)  state_next = S_FLUSH_DATA;
            S_FLUSH_DATA: if (flush_done) state_next = S_IDLE;
            S_RD_REQ:     if (req_ready)  state_next = S_RD_DATA;
            S_RD_DATA:    if (rd_done)    state_next = S_IDLE;
            default:                      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_refresh = 1'b0;
        req_addr    = '0;
        req_wmask   = 8'h00;
        req_wdata   = '0;
        case (state_reg)
            S_REFRESH: begin
                req_valid   = 1'b1;
                req_refresh = 1'b1;
            end
            S_FLUSH_REQ: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = {tag_reg, 3'b000};
                req_wmask = mask_reg;
            end
            S_FLUSH_DATA: req_wdata = line_reg[beat_reg];
            S_RD_REQ: begin
                req_valid = 1'b1;
                req_addr  = {rd_addr_reg[ADDR_W-1:3], 3'b000};
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    line_reg[gi] <= '0;
                else if (wr_accept && (wr_addr[2:0] == 3'(gi)))
                    line_reg[gi] <= wr_data;
            end
        end
    endgenerate

    always_comb begin
        mask_next = mask_reg;
        if (flush_done)
            mask_next = 8'h00;
        else if (wr_accept)
            mask_next[wr_addr[2:0]] = 1'b1;
    end

    // Simultaneous expiry and refresh handshake cancel out.
    always_comb begin
        debt_next = debt_reg;
        if (expire && !ref_hs) begin
            if (debt_reg != 4'd8) debt_next = debt_reg + 4'd1;
        end else if (ref_hs && !expire) begin
            debt_next = debt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_reg          <= 8'h00;
            tag_reg           <= '0;
            beat_reg          <= 3'd0;
            rd_addr_reg       <= '0;
            ref_cnt_reg       <= RC_W'(REFRESH_CYCLES - 1);
            debt_reg          <= 4'd0;
            idle_cnt_reg      <= '0;
            ctrl_ready_reg    <= 1'b0;
            rd_data_reg       <= '0;
            rd_data_valid_reg <= 1'b0;
            refresh_err_reg   <= 1'b0;
        end else begin
            ctrl_ready_reg <= ctrl_ready;
            mask_reg       <= mask_next;
            debt_reg       <= debt_next;
            if (wr_accept) tag_reg     <= wr_addr[ADDR_W-1:3];
            if (rd_accept) rd_addr_reg <= rd_addr;
            if (debt_next == 4'd8) refresh_err_reg <= 1'b1;

            if (ctrl_ready_reg)
                ref_cnt_reg <= expire ? RC_W'(REFRESH_CYCLES - 1) : ref_cnt_reg - 1'b1;

            if (mask_reg == 8'h00 || wr_accept)
                idle_cnt_reg <= '0;
            else if (state_reg == S_IDLE && idle_cnt_reg != IC_W'(FLUSH_TIMEOUT))
                idle_cnt_reg <= idle_cnt_reg + 1'b1;

            if (req_hs && !req_refresh)
                beat_reg <= 3'd0;
            else if ((state_reg == S_FLUSH_DATA && req_wdata_next) ||
                     (state_reg == S_RD_DATA && resp_valid))
                beat_reg <= beat_reg + 3'd1;

            rd_data_valid_reg <= 1'b0;
            if (state_reg == S_RD_DATA && resp_valid && beat_reg == rd_addr_reg[2:0]) begin
                rd_data_reg       <= resp_data;
                rd_data_valid_reg <= 1'b1;
            end
        end
    end

    assign rd_data       = rd_data_reg;
    assign rd_data_valid = rd_data_valid_reg;
    assign refresh_err   = refresh_err_reg;

endmodule
